// File: rtl/matrix_load_sequencer_pkg.sv
// Shared types and default sizing for the matrix load sequencer.
package matrix_load_sequencer_pkg;

   localparam int unsigned MLS_M          = 3;
   localparam int unsigned MLS_N          = 3;
   localparam int unsigned MLS_P          = 3;
   localparam int unsigned MLS_DATA_WIDTH = 8;
   localparam int unsigned MLS_TIMEOUT    = 1024;

   localparam int unsigned ADDR_A_W  = $clog2(MLS_M * MLS_N);
   localparam int unsigned ADDR_B_W  = $clog2(MLS_N * MLS_P);
   localparam int unsigned RES_IDX_W = $clog2(MLS_M * MLS_P) + 1;
   localparam int unsigned RES_W     = 2 * MLS_DATA_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_START  = 3'd3,
      S_WAIT   = 3'd4,
      S_DRAIN  = 3'd5
   } mls_state_e;

   function automatic int unsigned mls_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mls_result_buffer.sv
// Result buffer: simple dual-port RAM, synchronous write, registered read.
module mls_result_buffer
   import matrix_load_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH = MLS_M * MLS_P,
   parameter int unsigned AW    = RES_IDX_W - 1,
   parameter int unsigned DW    = RES_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rd_data_q;
   logic [DW-1:0] rd_data_d;

   // Storage array; contents are not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Write-through on an address collision so a beat captured on the same
   // edge as the prefetch of that slot is seen immediately.
   always_comb begin
      rd_data_d = mem_q[rd_addr];
      if (wr_en && (wr_addr == rd_addr)) begin
         rd_data_d = wr_data;
      end
   end

   // Registered read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/matrix_load_sequencer.sv
// Host-side load/start/result sequencer for the matrix accelerator.
module matrix_load_sequencer
   import matrix_load_sequencer_pkg::*;
#(
   parameter int unsigned M              = MLS_M,
   parameter int unsigned N              = MLS_N,
   parameter int unsigned P              = MLS_P,
   parameter int unsigned DATA_WIDTH     = MLS_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = MLS_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cmd_start,
   input  logic [1:0]                cmd_app_sel,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_data,
   output logic [DATA_WIDTH-1:0]     a_data_out,
   output logic [$clog2(M*N)-1:0]    a_addr,
   output logic                      a_wen,
   output logic [DATA_WIDTH-1:0]     b_data_out,
   output logic [$clog2(N*P)-1:0]    b_addr,
   output logic                      b_wen,
   output logic [1:0]                app_select,
   output logic                      start_computation,
   input  logic                      computation_done,
   input  logic [2*DATA_WIDTH-1:0]   result_in,
   input  logic                      result_valid,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [2*DATA_WIDTH-1:0]   res_data,
   output logic                      res_last,
   output logic                      busy,
   output logic                      err
);

   localparam int unsigned A_AW  = $clog2(M * N);
   localparam int unsigned B_AW  = $clog2(N * P);
   localparam int unsigned R_AW  = $clog2(M * P);
   localparam int unsigned R_IW  = R_AW + 1;
   localparam int unsigned RW    = 2 * DATA_WIDTH;
   localparam int unsigned LD_W  = $clog2(mls_max(M * N, N * P)) + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [LD_W-1:0]  A_LAST    = LD_W'(M * N - 1);
   localparam logic [LD_W-1:0]  B_LAST    = LD_W'(N * P - 1);
   localparam logic [R_IW-1:0]  RES_BEATS = R_IW'(M * P);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   mls_state_e state_q, state_d;

   logic [LD_W-1:0]       cnt_q, cnt_d;
   logic [R_IW-1:0]       wr_idx_q, wr_idx_d;
   logic [R_IW-1:0]       rd_idx_q, rd_idx_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  err_q, err_d;
   logic [1:0]            app_sel_q, app_sel_d;
   logic                  a_wen_q, a_wen_d;
   logic [A_AW-1:0]       a_addr_q, a_addr_d;
   logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
   logic                  b_wen_q, b_wen_d;
   logic [B_AW-1:0]       b_addr_q, b_addr_d;
   logic [DATA_WIDTH-1:0] b_data_q, b_data_d;

   logic            in_fire;
   logic            res_fire;
   logic            cap_ok;
   logic [R_IW-1:0] cap_cnt;
   logic            tmo_hit;
   logic            buf_we;
   logic [RW-1:0]   buf_rdata;

   assign in_fire  = in_valid && in_ready;
   assign res_fire = res_valid && res_ready;
   assign cap_ok   = result_valid && (wr_idx_q < RES_BEATS);
   assign cap_cnt  = wr_idx_q + R_IW'(cap_ok);
   assign tmo_hit  = (tmo_q == TMO_LAST);
   assign buf_we   = (state_q == S_WAIT) && cap_ok;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (cmd_start) state_d = S_LOAD_A;
         S_LOAD_A: if (in_fire && (cnt_q == A_LAST)) state_d = S_LOAD_B;
         S_LOAD_B: if (in_fire && (cnt_q == B_LAST)) state_d = S_START;
         S_START:  state_d = S_WAIT;
         S_WAIT: begin
            // Done wins over a coincident timeout; nothing captured means nothing to drain.
            if (computation_done) begin
               state_d = (cap_cnt == '0) ? S_IDLE : S_DRAIN;
            end else if (tmo_hit) begin
               state_d = S_IDLE;
            end
         end
         S_DRAIN:  if (res_fire && res_last) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      in_ready          = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
      busy              = (state_q != S_IDLE);
      start_computation = (state_q == S_START);
      res_valid         = (state_q == S_DRAIN);
      res_last          = (state_q == S_DRAIN) && (rd_idx_q == (wr_idx_q - R_IW'(1)));
      res_data          = (state_q == S_DRAIN) ? buf_rdata : '0;
   end

   // Datapath next values: counters, write ports, error and app select.
   always_comb begin
      cnt_d     = cnt_q;
      wr_idx_d  = wr_idx_q;
      rd_idx_d  = rd_idx_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      app_sel_d = app_sel_q;
      a_wen_d   = 1'b0;
      a_addr_d  = a_addr_q;
      a_data_d  = a_data_q;
      b_wen_d   = 1'b0;
      b_addr_d  = b_addr_q;
      b_data_d  = b_data_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_start) begin
               app_sel_d = cmd_app_sel;
               err_d     = 1'b0;
               cnt_d     = '0;
               wr_idx_d  = '0;
               rd_idx_d  = '0;
               tmo_d     = '0;
            end
         end
         S_LOAD_A: begin
            if (in_fire) begin
               a_wen_d  = 1'b1;
               a_addr_d = cnt_q[A_AW-1:0];
               a_data_d = in_data;
               cnt_d    = (cnt_q == A_LAST) ? '0 : cnt_q + LD_W'(1);
            end
         end
         S_LOAD_B: begin
            if (in_fire) begin
               b_wen_d  = 1'b1;
               b_addr_d = cnt_q[B_AW-1:0];
               b_data_d = in_data;
               cnt_d    = (cnt_q == B_LAST) ? '0 : cnt_q + LD_W'(1);
            end
         end
         S_START: begin
         end
         S_WAIT: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (result_valid) begin
               if (cap_ok) wr_idx_d = wr_idx_q + R_IW'(1);
               else        err_d    = 1'b1;
            end
            if (computation_done) begin
               if (cap_cnt != RES_BEATS) err_d = 1'b1;
            end else if (tmo_hit) begin
               err_d = 1'b1;
            end
         end
         S_DRAIN: begin
            if (res_fire && !res_last) rd_idx_d = rd_idx_q + R_IW'(1);
         end
         default: begin
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         tmo_q     <= '0;
         err_q     <= 1'b0;
         app_sel_q <= '0;
         a_wen_q   <= 1'b0;
         a_addr_q  <= '0;
         a_data_q  <= '0;
         b_wen_q   <= 1'b0;
         b_addr_q  <= '0;
         b_data_q  <= '0;
      end else begin
         cnt_q     <= cnt_d;
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         app_sel_q <= app_sel_d;
         a_wen_q   <= a_wen_d;
         a_addr_q  <= a_addr_d;
         a_data_q  <= a_data_d;
         b_wen_q   <= b_wen_d;
         b_addr_q  <= b_addr_d;
         b_data_q  <= b_data_d;
      end
   end

   assign a_wen      = a_wen_q;
   assign a_addr     = a_addr_q;
   assign a_data_out = a_data_q;
   assign b_wen      = b_wen_q;
   assign b_addr     = b_addr_q;
   assign b_data_out = b_data_q;
   assign app_select = app_sel_q;
   assign err        = err_q;

   // Read address is the next index, so the registered read lands on the
   // cycle res_valid rises and stays put while the host stalls.
   mls_result_buffer #(
      .DEPTH (M * P),
      .AW    (R_AW),
      .DW    (RW)
   ) u_result_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (buf_we),
      .wr_addr (wr_idx_q[R_AW-1:0]),
      .wr_data (result_in),
      .rd_addr (rd_idx_d[R_AW-1:0]),
      .rd_data (buf_rdata)
   );

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Directed bench for matrix_load_sequencer with a behavioural accelerator.
module tb_matrix_load_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_start;
   logic [1:0]  cmd_app_sel;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [7:0]  a_data_out;
   logic [3:0]  a_addr;
   logic        a_wen;
   logic [7:0]  b_data_out;
   logic [3:0]  b_addr;
   logic        b_wen;
   logic [1:0]  app_select;
   logic        start_computation;
   logic        computation_done;
   logic [15:0] result_in;
   logic        result_valid;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        res_last;
   logic        busy;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  stim  [18];
   logic [15:0] exp_c [9];

   logic [3:0]  a_addr_log [32];
   logic [7:0]  a_dat_log  [32];
   logic [3:0]  b_addr_log [32];
   logic [7:0]  b_dat_log  [32];
   logic [15:0] res_log    [32];
   logic        last_log   [32];
   int a_n = 0, b_n = 0, res_n = 0, start_n = 0, res_v_cycles = 0;
   int stall_viol = 0, wen_viol = 0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data  = '0;

   matrix_load_sequencer #(
      .M (3), .N (3), .P (3), .DATA_WIDTH (8), .TIMEOUT_CYCLES (1024)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cmd_start         (cmd_start),
      .cmd_app_sel       (cmd_app_sel),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .a_data_out        (a_data_out),
      .a_addr            (a_addr),
      .a_wen             (a_wen),
      .b_data_out        (b_data_out),
      .b_addr            (b_addr),
      .b_wen             (b_wen),
      .app_select        (app_select),
      .start_computation (start_computation),
      .computation_done  (computation_done),
      .result_in         (result_in),
      .result_valid      (result_valid),
      .res_valid         (res_valid),
      .res_ready         (res_ready),
      .res_data          (res_data),
      .res_last          (res_last),
      .busy              (busy),
      .err               (err)
   );

   always #5 clk = ~clk;

   // Observe the accelerator and host sides on the falling edge.
   always @(negedge clk) begin
      if (a_wen) begin
         if (a_n < 32) begin a_addr_log[a_n] = a_addr; a_dat_log[a_n] = a_data_out; end
         a_n++;
      end
      if (b_wen) begin
         if (b_n < 32) begin b_addr_log[b_n] = b_addr; b_dat_log[b_n] = b_data_out; end
         b_n++;
      end
      if (a_wen && b_wen) wen_viol++;
      if (start_computation) start_n++;
      if (res_valid) res_v_cycles++;
      if (prev_stall && res_valid && (res_data != prev_data)) stall_viol++;
      if (res_valid && res_ready) begin
         if (res_n < 32) begin res_log[res_n] = res_data; last_log[res_n] = res_last; end
         res_n++;
      end
      prev_stall = res_valid && !res_ready;
      prev_data  = res_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      a_n = 0; b_n = 0; res_n = 0; start_n = 0; res_v_cycles = 0; stall_viol = 0;
   endtask

   // kind 0: A and B identity; kind 1: A = 1..9, B = 9..1. exp_c = A*B.
   task automatic make_pattern(input int kind);
      for (int i = 0; i < 9; i++) begin
         if (kind == 0) begin
            stim[i]     = ((i % 4) == 0) ? 8'd1 : 8'd0;
            stim[9 + i] = ((i % 4) == 0) ? 8'd1 : 8'd0;
         end else begin
            stim[i]     = 8'(i + 1);
            stim[9 + i] = 8'(9 - i);
         end
      end
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            int acc;
            acc = 0;
            for (int k = 0; k < 3; k++) acc += int'(stim[r*3 + k]) * int'(stim[9 + k*3 + c]);
            exp_c[r*3 + c] = 16'(acc);
         end
      end
   endtask

   task automatic start_job(input logic [1:0] sel);
      cmd_app_sel = sel;
      cmd_start   = 1'b1;
      tick();
      cmd_start   = 1'b0;
   endtask

   task automatic load_range(input int first, input int last, input bit bursty);
      int  i;
      int  guard;
      bit  fire;
      i = first;
      guard = 0;
      while (i <= last && guard < 400) begin
         in_valid = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = stim[i];
         @(negedge clk);
         fire = in_valid && in_ready;
         tick();
         if (fire) i++;
         guard++;
      end
      in_valid = 1'b0;
      if (i <= last) chk("load_budget", i, last + 1);
   endtask

   // Called while in START: steps into WAIT, streams results, then done.
   task automatic run_accel(input int nbeats, input bit coincide);
      tick();
      for (int j = 0; j < nbeats; j++) begin
         result_valid     = 1'b1;
         result_in        = exp_c[j];
         computation_done = coincide && (j == nbeats - 1);
         tick();
      end
      result_valid     = 1'b0;
      computation_done = 1'b0;
      if (!coincide) begin
         computation_done = 1'b1;
         tick();
         computation_done = 1'b0;
      end
   endtask

   task automatic drain(input int stall_from, input int stall_len);
      for (int j = 0; j < 80 && busy; j++) begin
         res_ready = !(j >= stall_from && j < stall_from + stall_len);
         tick();
      end
      res_ready = 1'b0;
      if (busy) chk("drain_budget", busy, 0);
   endtask

   task automatic check_writes(input string tn);
      chk({tn, "_a_n"}, a_n, 9);
      chk({tn, "_b_n"}, b_n, 9);
      for (int i = 0; i < 9; i++) begin
         if (i < a_n) begin
            chk($sformatf("%s_a_addr%0d", tn, i), a_addr_log[i], i);
            chk($sformatf("%s_a_dat%0d", tn, i), a_dat_log[i], stim[i]);
         end
         if (i < b_n) begin
            chk($sformatf("%s_b_addr%0d", tn, i), b_addr_log[i], i);
            chk($sformatf("%s_b_dat%0d", tn, i), b_dat_log[i], stim[9 + i]);
         end
      end
   endtask

   task automatic check_results(input string tn, input int nexp);
      chk({tn, "_res_n"}, res_n, nexp);
      for (int i = 0; i < nexp && i < res_n; i++) begin
         chk($sformatf("%s_res%0d", tn, i), res_log[i], exp_c[i]);
         chk($sformatf("%s_last%0d", tn, i), last_log[i], (i == nexp - 1) ? 1 : 0);
      end
   endtask

   initial begin
      int n;
      rst_n = 1'b0; cmd_start = 1'b0; cmd_app_sel = '0; in_valid = 1'b0; in_data = '0;
      computation_done = 1'b0; result_in = '0; result_valid = 1'b0; res_ready = 1'b0;
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_a_wen", a_wen, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_app_sel", app_select, 0);
      rst_n = 1'b1;
      tick();

      // Identity load and result
      make_pattern(0); clear_logs();
      start_job(2'd0);
      chk("t1_busy", busy, 1);
      chk("t1_in_ready", in_ready, 1);
      load_range(0, 17, 1'b0);
      chk("t1_start", start_computation, 1);
      chk("t1_start_rdy", in_ready, 0);
      run_accel(9, 1'b0);
      drain(100, 0);
      check_writes("t1");
      check_results("t1", 9);
      chk("t1_start_n", start_n, 1);
      chk("t1_err", err, 0);
      chk("t1_busy_end", busy, 0);

      // Bursty input with a non-trivial product
      make_pattern(1); clear_logs();
      start_job(2'd2);
      chk("t2_app_sel", app_select, 2);
      load_range(0, 17, 1'b1);
      run_accel(9, 1'b0);
      drain(100, 0);
      check_writes("t2");
      check_results("t2", 9);
      chk("t2_err", err, 0);

      // Host stall mid-drain
      clear_logs();
      start_job(2'd1);
      load_range(0, 17, 1'b0);
      run_accel(9, 1'b0);
      drain(3, 5);
      check_results("t3", 9);
      chk("t3_stall_stable", stall_viol, 0);
      chk("t3_err", err, 0);

      // Timeout: done never arrives
      make_pattern(0); clear_logs();
      start_job(2'd0);
      load_range(0, 17, 1'b0);
      n = 0;
      while (busy && n < 1100) begin tick(); n++; end
      chk("t4_cycles", n, 1025);
      chk("t4_err", err, 1);
      chk("t4_busy", busy, 0);
      chk("t4_res_valid_seen", res_v_cycles, 0);

      // Short result: 7 beats, done on the 7th
      clear_logs();
      start_job(2'd0);
      chk("t5_err_cleared", err, 0);
      load_range(0, 17, 1'b0);
      run_accel(7, 1'b1);
      drain(100, 0);
      check_results("t5", 7);
      chk("t5_err", err, 1);

      // cmd_start during LOAD_B is ignored
      clear_logs();
      start_job(2'd1);
      load_range(0, 11, 1'b0);
      cmd_app_sel = 2'd3; cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
      chk("t6_app_sel", app_select, 1);
      chk("t6_busy", busy, 1);
      chk("t6_in_ready", in_ready, 1);
      chk("t6_err", err, 0);
      load_range(12, 17, 1'b0);
      run_accel(9, 1'b0);
      drain(100, 0);
      check_writes("t6");
      check_results("t6", 9);
      chk("t6_start_n", start_n, 1);

      // Asynchronous reset mid-LOAD_A, then a clean job
      make_pattern(1); clear_logs();
      start_job(2'd2);
      load_range(0, 3, 1'b0);
      chk("t7_pre_a_wen", a_wen, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_a_wen", a_wen, 0);
      chk("t7_a_addr", a_addr, 0);
      chk("t7_a_data", a_data_out, 0);
      chk("t7_busy", busy, 0);
      chk("t7_in_ready", in_ready, 0);
      chk("t7_app_sel", app_select, 0);
      chk("t7_res_valid", res_valid, 0);
      tick();
      rst_n = 1'b1;
      tick();
      make_pattern(0); clear_logs();
      start_job(2'd0);
      load_range(0, 17, 1'b0);
      run_accel(9, 1'b0);
      drain(100, 0);
      check_writes("t8");
      check_results("t8", 9);
      chk("t8_err", err, 0);

      chk("wen_exclusive", wen_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_load_sequencer.md
Name: matrix_load_sequencer

Overview:
Host-side initiator for the matrix accelerator's load/start/result interface. It accepts a valid/ready byte stream from the host, writes the first M*N beats to the A buffer and the next N*P beats to the B buffer, and pulses start. It then buffers the accelerator's unthrottled result stream and replays it to the host on a valid/ready channel. It sits between the host bus adapter and matrix_accelerator_top.

Parameters:
M, 3, rows of A / rows of C
N, 3, cols of A / rows of B
P, 3, cols of B / cols of C
DATA_WIDTH, 8, operand width; result width is 2*DATA_WIDTH
TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before abort

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_start  in  1  one-cycle request to begin a job; honoured only in IDLE
cmd_app_sel  in  2  application select, latched on accepted cmd_start
in_valid  in  1  host operand beat valid
in_ready  out  1  sequencer can accept an operand beat
in_data  in  DATA_WIDTH  operand value, row-major
a_data_out  out  DATA_WIDTH  to accelerator a_data_in
a_addr  out  clog2(M*N)  to accelerator a_addr
a_wen  out  1  to accelerator a_wen
b_data_out  out  DATA_WIDTH  to accelerator b_data_in
b_addr  out  clog2(N*P)  to accelerator b_addr
b_wen  out  1  to accelerator b_wen
app_select  out  2  to accelerator, held for the whole job
start_computation  out  1  one-cycle start pulse
computation_done  in  1  from accelerator
result_in  in  2*DATA_WIDTH  from accelerator result_out
result_valid  in  1  from accelerator; no backpressure
res_valid  out  1  host result beat valid
res_ready  in  1  host accepts result beat
res_data  out  2*DATA_WIDTH  result value, row-major
res_last  out  1  high on the final beat (index M*P-1)
busy  out  1  high in every state except IDLE
err  out  1  sticky error, cleared on the next accepted cmd_start

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0, app_select 0.
- States: IDLE, LOAD_A, LOAD_B, START, WAIT, DRAIN.
- IDLE: on cmd_start, latch cmd_app_sel into app_select, clear err and the counters, go to LOAD_A.
- LOAD_A: in_ready=1. On each in_valid&&in_ready, the next cycle shows a_wen=1, a_addr=count and a_data_out=in_data (registered, latency 1). After beat M*N-1 go to LOAD_B. No lost or duplicated beats across gaps in in_valid.
- LOAD_B: same rules using the b_* ports. After beat N*P-1 go to START.
- START: start_computation=1 for exactly one cycle; in_ready=0. Go to WAIT.
- WAIT: each result_valid cycle writes result_in into the internal buffer (depth M*P) at wr_idx, then wr_idx increments.
  - Beats beyond M*P are dropped and set err.
  - On computation_done, go to DRAIN. If result_valid coincides with computation_done, that beat is captured first and counts.
  - If fewer than M*P beats were captured at done, set err; DRAIN then replays only the captured beats, with res_last on the last of them.
  - The timeout counter runs in WAIT. When it reaches TIMEOUT_CYCLES, set err and go to IDLE with no drain.
- DRAIN: res_valid=1 and res_data=buf[rd_idx]. rd_idx advances on res_valid&&res_ready. res_data is stable while stalled. After the res_last handshake, go to IDLE.
- cmd_start outside IDLE is ignored: no state change and err unaffected.
- in_valid outside the LOAD states is ignored (in_ready=0).
- a_wen and b_wen are never high in the same cycle.
- Asynchronous reset mid-job aborts immediately to reset values. The accelerator buffers are not cleared.
- Throughput: one operand beat per cycle. Minimum job length is M*N+N*P+2 cycles plus accelerator latency plus M*P drain cycles.

Decomposition:
- Shared package holds: the state encoding, the address-width constants ADDR_A_W=clog2(M*N), ADDR_B_W=clog2(N*P), RES_IDX_W=clog2(M*P)+1, and RES_W=2*DATA_WIDTH.
- One sub-module, mls_result_buffer: simple dual-port RAM of M*P x RES_W, with a synchronous write port and a registered read port. The sequencer pre-fetches the read so res_data is valid on the cycle res_valid rises.

Test Plan:
- Identity load: cmd_start with app_sel=0, then 18 beats with identity pattern (a_addr 0/4/8 = 1) -> a_wen writes addr 0..8 then b_wen writes 0..8; exactly one start pulse; behavioural accelerator returns identity -> 9 res beats 1,0,0,0,1,0,0,0,1 with res_last on the 9th; err=0; busy falls.
- Bursty input: in_valid toggled randomly at about 50% -> same write sequence and values, no gaps or duplicates in addresses.
- Host stall: res_ready low for 5 cycles mid-drain -> res_data stable while stalled; all 9 values delivered in order.
- Timeout: model never asserts computation_done -> after 1024 WAIT cycles err=1, state IDLE, res_valid never high.
- Short result: only 7 result beats, then done coincides with the 7th -> 7 beats drained, res_last on the 7th, err=1.
- Reset and illegal start: cmd_start pulsed during LOAD_B is ignored; rst_n asserted mid-LOAD_A -> all outputs 0 asynchronously; a new job afterwards completes correctly.
